// File: rtl/incline_filter_pkg.sv
// Shared types and constants for the incline filter.
//   state_t   : filter FSM states (window filling, running, stream stale)
//   IN_W      : width of the raw signed incline sample from the inertial interface
//   SAT_W_DEF : default clamped width
//   SAT_MAX   : upper clamp bound for the default width
//   SAT_MIN   : lower clamp bound for the default width
package incline_filter_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    STALE = 2'd2
  } state_t;

  localparam int IN_W      = 13;
  localparam int SAT_W_DEF = 10;
  localparam int SAT_MAX   = 511;
  localparam int SAT_MIN   = -512;

endpackage

// File: rtl/incline_filter_if.sv
// Sample stream into the filter and filtered stream out to the assist/torque stage.
//   incline      : signed raw incline sample
//   vld          : one-cycle strobe, incline valid
//   clr          : synchronous flush of filter history
//   incline_filt : signed filtered incline, held between updates
//   filt_vld     : one-cycle strobe, incline_filt updated while primed
//   primed       : averaging window is full
//   stale        : no sample seen for the stale timeout
// master drives samples (IMU side), slave is the filter.
interface incline_filter_if #(
  parameter int SAT_W = 10
);

  logic signed [12:0]      incline;
  logic                    vld;
  logic                    clr;
  logic signed [SAT_W-1:0] incline_filt;
  logic                    filt_vld;
  logic                    primed;
  logic                    stale;

  modport master (
    output incline, vld, clr,
    input  incline_filt, filt_vld, primed, stale
  );

  modport slave (
    input  incline, vld, clr,
    output incline_filt, filt_vld, primed, stale
  );

endinterface

// File: rtl/incline_sat.sv
// Combinational clamp of a 13-bit signed sample into SAT_W signed bits.
//   incline : raw signed sample
//   sat     : sample clamped to [-2^(SAT_W-1), 2^(SAT_W-1)-1]
module incline_sat
  import incline_filter_pkg::*;
#(
  parameter int SAT_W = SAT_W_DEF
) (
  input  logic signed [IN_W-1:0]  incline,
  output logic signed [SAT_W-1:0] sat
);

  localparam logic signed [IN_W-1:0] HI = IN_W'((1 <<< (SAT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] LO = IN_W'(-(1 <<< (SAT_W - 1)));

  // Clamp to the representable range, otherwise pass the low bits through.
  always_comb begin
    sat = '0;
    if (incline > HI) begin
      sat = HI[SAT_W-1:0];
    end else if (incline < LO) begin
      sat = LO[SAT_W-1:0];
    end else begin
      sat = incline[SAT_W-1:0];
    end
  end

endmodule

// File: rtl/incline_filter.sv
// Incline conditioner: clamps each sample, keeps a 2^DEPTH_LOG2 boxcar average
// in a ring buffer and flags a stalled sample stream.
//   clk  : system clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : incline_filter_if.slave (samples in, filtered incline and status out)
module incline_filter
  import incline_filter_pkg::*;
#(
  parameter int DEPTH_LOG2   = 3,
  parameter int SAT_W        = SAT_W_DEF,
  parameter int STALE_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  incline_filter_if.slave bus
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int SUM_W   = SAT_W + DEPTH_LOG2;
  localparam int FILL_W  = DEPTH_LOG2 + 1;
  localparam int TIMER_W = (STALE_CYCLES > 2) ? $clog2(STALE_CYCLES) : 1;

  state_t                  state_r;
  state_t                  state_next_s;
  logic signed [SAT_W-1:0] ring_r [DEPTH];
  logic signed [SUM_W-1:0] sum_r;
  logic [DEPTH_LOG2-1:0]   wr_ptr_r;
  logic [FILL_W-1:0]       fill_cnt_r;
  logic [TIMER_W-1:0]      timer_r;
  logic signed [SAT_W-1:0] filt_r;
  logic                    filt_vld_r;
  logic                    primed_r;
  logic                    stale_r;

  logic signed [SAT_W-1:0] sat_s;
  logic signed [SAT_W-1:0] old_s;
  logic signed [SUM_W-1:0] sat_ext_s;
  logic signed [SUM_W-1:0] old_ext_s;
  logic signed [SUM_W-1:0] sum_next_s;
  logic signed [SUM_W-1:0] avg_s;
  logic [FILL_W-1:0]       fill_next_s;
  logic                    window_full_s;
  logic                    accept_s;
  logic                    stale_hit_s;

  incline_sat #(.SAT_W(SAT_W)) u_sat (
    .incline (bus.incline),
    .sat     (sat_s)
  );

  // Running-sum update, fill count and stale-timeout detection for this cycle.
  always_comb begin
    old_s         = ring_r[wr_ptr_r];
    sat_ext_s     = {{DEPTH_LOG2{sat_s[SAT_W-1]}}, sat_s};
    old_ext_s     = {{DEPTH_LOG2{old_s[SAT_W-1]}}, old_s};
    // Evicted entry is subtracted; flushed entries read 0 so the sum never overflows.
    sum_next_s    = sum_r + sat_ext_s - old_ext_s;
    avg_s         = sum_next_s >>> DEPTH_LOG2;
    fill_next_s   = fill_cnt_r;
    if (fill_cnt_r == FILL_W'(DEPTH)) begin
      fill_next_s = fill_cnt_r;
    end else begin
      fill_next_s = fill_cnt_r + FILL_W'(1);
    end
    window_full_s = (fill_next_s == FILL_W'(DEPTH));
    accept_s      = bus.vld && !bus.clr;
    stale_hit_s   = (state_r != STALE) && !bus.vld && !bus.clr &&
                    (timer_r == TIMER_W'(STALE_CYCLES - 1));
  end

  // FSM next-state decode; clr always returns to FILL.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FILL: begin
        if (bus.clr) begin
          state_next_s = FILL;
        end else if (bus.vld && window_full_s) begin
          state_next_s = RUN;
        end else if (stale_hit_s) begin
          state_next_s = STALE;
        end else begin
          state_next_s = FILL;
        end
      end
      RUN: begin
        if (bus.clr) begin
          state_next_s = FILL;
        end else if (stale_hit_s) begin
          state_next_s = STALE;
        end else begin
          state_next_s = RUN;
        end
      end
      STALE: begin
        if (bus.clr || bus.vld) begin
          state_next_s = FILL;
        end else begin
          state_next_s = STALE;
        end
      end
      default: begin
        state_next_s = FILL;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FILL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Ring buffer, accumulator, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_r[i] <= '0;
      end
      sum_r      <= '0;
      wr_ptr_r   <= '0;
      fill_cnt_r <= '0;
      timer_r    <= '0;
      filt_r     <= '0;
      filt_vld_r <= 1'b0;
      primed_r   <= 1'b0;
      stale_r    <= 1'b0;
    end else if (bus.clr || stale_hit_s) begin
      // Flush history; incline_filt keeps its last value.
      for (int i = 0; i < DEPTH; i++) begin
        ring_r[i] <= '0;
      end
      sum_r      <= '0;
      wr_ptr_r   <= '0;
      fill_cnt_r <= '0;
      timer_r    <= '0;
      filt_vld_r <= 1'b0;
      primed_r   <= 1'b0;
      stale_r    <= stale_hit_s ? 1'b1 : stale_r;
    end else if (accept_s) begin
      ring_r[wr_ptr_r] <= sat_s;
      sum_r            <= sum_next_s;
      wr_ptr_r         <= wr_ptr_r + DEPTH_LOG2'(1);
      fill_cnt_r       <= fill_next_s;
      timer_r          <= '0;
      filt_r           <= avg_s[SAT_W-1:0];
      filt_vld_r       <= window_full_s;
      primed_r         <= window_full_s;
      stale_r          <= 1'b0;
    end else begin
      filt_vld_r <= 1'b0;
      if (state_r == STALE) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_r + TIMER_W'(1);
      end
    end
  end

  assign bus.incline_filt = filt_r;
  assign bus.filt_vld     = filt_vld_r;
  assign bus.primed       = primed_r;
  assign bus.stale        = stale_r;

endmodule

// File: tb/tb_incline_filter.sv
module tb_incline_filter;
  import incline_filter_pkg::*;

  localparam int L     = 3;
  localparam int DEPTH = 8;
  localparam int W     = 10;
  localparam int S     = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  incline_filter_if #(.SAT_W(W)) bus ();

  incline_filter #(.DEPTH_LOG2(L), .SAT_W(W), .STALE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [12:0]  sat_in;
  logic signed [W-1:0] sat_out;

  incline_sat #(.SAT_W(W)) u_sat_alone (
    .incline (sat_in),
    .sat     (sat_out)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: window of accepted clamped samples, oldest first.
  int win[$];
  int m_filt;
  bit m_fv, m_primed, m_stale, m_frozen;
  int idle;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > SAT_MAX) return SAT_MAX;
    else if (v < SAT_MIN) return SAT_MIN;
    else return v;
  endfunction

  function automatic int floor_avg();
    int s = 0;
    foreach (win[i]) s += win[i];
    if (s >= 0) return s / DEPTH;
    else return -((-s + DEPTH - 1) / DEPTH);
  endfunction

  task automatic model_reset();
    win.delete();
    m_filt = 0; m_fv = 0; m_primed = 0; m_stale = 0; m_frozen = 0; idle = 0;
  endtask

  task automatic model_edge(input bit v, input int val, input bit c);
    m_fv = 0;
    if (c) begin
      win.delete(); m_primed = 0; m_frozen = 0; idle = 0;
    end else if (v) begin
      win.push_back(clamp(val));
      if (win.size() > DEPTH) void'(win.pop_front());
      m_filt = floor_avg();
      m_fv = (win.size() == DEPTH);
      m_primed = m_fv;
      m_stale = 0; m_frozen = 0; idle = 0;
    end else if (!m_frozen && idle == S - 1) begin
      win.delete(); m_primed = 0; m_stale = 1; m_frozen = 1; idle = 0;
    end else if (!m_frozen) begin
      idle++;
    end
  endtask

  task automatic compare_outputs();
    check_val("filt",   int'(bus.incline_filt), m_filt);
    check_val("fvld",   int'(bus.filt_vld),     int'(m_fv));
    check_val("primed", int'(bus.primed),       int'(m_primed));
    check_val("stale",  int'(bus.stale),        int'(m_stale));
  endtask

  task automatic cycle(input bit v, input int val, input bit c);
    @(negedge clk);
    rst = 1'b0; bus.vld = v; bus.incline = 13'(val); bus.clr = c;
    @(posedge clk);
    model_edge(v, val, c);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; bus.vld = 1'b1; bus.incline = 13'(300); bus.clr = 1'b0;
    repeat (n) @(posedge clk);
    model_reset();
    #1;
    compare_outputs();
  endtask

  task automatic send(input int val);
    cycle(1'b1, val, 1'b0);
  endtask

  task automatic gap(input int n);
    repeat (n) cycle(1'b0, 0, 1'b0);
  endtask

  int prime_exp [8] = '{12, 25, 37, 50, 62, 75, 87, 100};
  int sat_vec   [8] = '{-4096, -513, -512, -1, 0, 511, 512, 4095};

  initial begin
    bus.vld = 1'b0; bus.clr = 1'b0; bus.incline = '0;
    model_reset();

    // Stand-alone clamp unit.
    for (int i = 0; i < 28; i++) begin
      int v;
      v = (i < 8) ? sat_vec[i] : int'($urandom_range(0, 8191)) - 4096;
      sat_in = 13'(v);
      #1;
      check_val("sat_unit", int'(sat_out), clamp(v));
    end

    do_reset(2);

    // Priming: eight samples of 100, three cycles apart.
    for (int k = 0; k < 8; k++) begin
      send(100);
      check_val("prime_seq", int'(bus.incline_filt), prime_exp[k]);
      if (k < 7) gap(2);
    end
    check_val("prime_fv", int'(bus.filt_vld), 1);
    check_val("prime_p", int'(bus.primed), 1);

    // Saturation in both directions.
    repeat (8) send(4095);
    check_val("sat_hi", int'(bus.incline_filt), 511);
    repeat (8) send(-4096);
    check_val("sat_lo", int'(bus.incline_filt), -512);

    // Floor rounding and eviction.
    repeat (7) send(0);
    send(-1);
    check_val("floor_m1", int'(bus.incline_filt), -1);
    repeat (7) send(0);
    check_val("evict_pre", int'(bus.incline_filt), -1);
    send(0);
    check_val("evict", int'(bus.incline_filt), 0);

    // Stale timeout while primed.
    send(24);
    check_val("pre_stale", int'(bus.incline_filt), 3);
    gap(S - 1);
    check_val("stale_early", int'(bus.stale), 0);
    gap(1);
    check_val("stale_set", int'(bus.stale), 1);
    check_val("stale_p", int'(bus.primed), 0);
    check_val("stale_hold", int'(bus.incline_filt), 3);
    send(40);
    check_val("restart", int'(bus.incline_filt), 5);
    check_val("restart_st", int'(bus.stale), 0);
    check_val("restart_fv", int'(bus.filt_vld), 0);

    // clr together with vld drops the sample.
    repeat (7) send(100);
    check_val("clr_prep", int'(bus.primed), 1);
    cycle(1'b1, 100, 1'b1);
    check_val("clr_p", int'(bus.primed), 0);
    check_val("clr_fv", int'(bus.filt_vld), 0);
    send(80);
    check_val("clr_next", int'(bus.incline_filt), 10);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      int r, val;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 1) == 0) val = int'($urandom_range(0, 8191)) - 4096;
      else val = int'($urandom_range(0, 1200)) - 600;
      if (r < 1) begin
        do_reset(1);
      end else if (r < 4) begin
        cycle(1'($urandom_range(0, 1)), val, 1'b1);
      end else if (r < 5) begin
        gap(int'($urandom_range(S - 5, S + 5)));
      end else begin
        cycle(r < 60, val, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
